// File: rtl/bram_rd_stream_if.sv
// Bundle of control, BRAM read-port and output-stream signals for bram_rd_stream.
// master = the streaming reader; slave = the surrounding system (controller, BRAM, sink).
interface bram_rd_stream_if #(
   parameter int AW = 10,
   parameter int DW = 16
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addrb;
   logic          ram_enb;
   logic          ram_regceb;
   logic [DW-1:0] ram_doutb;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;

   modport master (
      input  start, base_addr, length, ram_doutb, m_ready,
      output busy, done, ram_addrb, ram_enb, ram_regceb, m_data, m_valid, m_last
   );

   modport slave (
      output start, base_addr, length, ram_doutb, m_ready,
      input  busy, done, ram_addrb, ram_enb, ram_regceb, m_data, m_valid, m_last
   );
endinterface

// File: rtl/bram_rd_stream.sv
// Streams a burst of consecutive BRAM words out through a small credit-managed FIFO.
// Reads are only issued when every in-flight word is guaranteed a FIFO slot.
module bram_rd_stream #(
   parameter int    RAM_WIDTH       = 16,
   parameter int    RAM_DEPTH       = 1024,
   parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
   parameter int    FIFO_DEPTH      = 4
) (
   input logic              clka,
   input logic              rstb,
   bram_rd_stream_if.master bus
);
   localparam int AW = $clog2(RAM_DEPTH);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam bit HP = (RAM_PERFORMANCE == "HIGH_PERFORMANCE");

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t               r_state;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_ram_enb;
   logic [AW-1:0]        r_ram_addrb;
   logic [AW-1:0]        r_next_addr;
   logic [AW:0]          r_issue_left;
   logic [AW:0]          r_wr_left;
   logic [FW:0]          r_inflight;
   logic                 r_en_d1;
   logic                 r_en_d2;
   logic [RAM_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic                 r_last_mem [FIFO_DEPTH];
   logic [FW-1:0]        r_wr_ptr;
   logic [FW-1:0]        r_rd_ptr;
   logic [FW:0]          r_count;

   logic                 w_valid;
   logic                 w_wr;
   logic                 w_rd;
   logic                 w_last_xfer;
   logic [FW+1:0]        w_occ;
   logic                 w_credit;
   logic                 w_accept;
   logic                 w_issue;

   function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a);
      if (a == AW'(RAM_DEPTH - 1)) begin
         return '0;
      end else begin
         return a + AW'(1);
      end
   endfunction

   // Data lands in the FIFO one or two cycles after issue, depending on the BRAM output register.
   assign w_wr        = HP ? r_en_d2 : r_en_d1;
   assign w_valid     = (r_count != (FW+1)'(0));
   assign w_rd        = w_valid & bus.m_ready;
   assign w_last_xfer = w_rd & r_last_mem[r_rd_ptr];
   assign w_occ       = {1'b0, r_inflight} + {1'b0, r_count} - {{(FW+1){1'b0}}, w_rd};
   assign w_credit    = (w_occ < (FW+2)'(FIFO_DEPTH));

   // Decide whether a read is committed this cycle.
   always_comb begin
      w_accept = 1'b0;
      w_issue  = 1'b0;
      if (r_state == S_IDLE) begin
         w_accept = bus.start && (bus.length != (AW+1)'(0));
         w_issue  = w_accept;
      end else if (r_state == S_RUN) begin
         w_issue  = w_credit;
      end else begin
         w_issue  = 1'b0;
      end
   end

   // Burst control FSM with registered handshake and BRAM port outputs.
   always_ff @(posedge clka) begin
      if (rstb) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_ram_enb    <= 1'b0;
         r_ram_addrb  <= '0;
         r_next_addr  <= '0;
         r_issue_left <= '0;
         r_inflight   <= '0;
      end else begin
         r_done     <= 1'b0;
         r_ram_enb  <= w_issue;
         r_inflight <= r_inflight + {{FW{1'b0}}, w_issue} - {{FW{1'b0}}, w_wr};
         case (r_state)
            S_IDLE: begin
               if (bus.start && (bus.length == (AW+1)'(0))) begin
                  r_done <= 1'b1;
               end else if (w_accept) begin
                  r_busy       <= 1'b1;
                  r_ram_addrb  <= bus.base_addr;
                  r_next_addr  <= f_next_addr(bus.base_addr);
                  r_issue_left <= bus.length - (AW+1)'(1);
                  r_state      <= (bus.length == (AW+1)'(1)) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (w_credit) begin
                  r_ram_addrb  <= r_next_addr;
                  r_next_addr  <= f_next_addr(r_next_addr);
                  r_issue_left <= r_issue_left - (AW+1)'(1);
                  if (r_issue_left == (AW+1)'(1)) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_last_xfer) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read-latency pipeline and FIFO pointers; reset drops anything still in the BRAM pipe.
   always_ff @(posedge clka) begin
      if (rstb) begin
         r_en_d1   <= 1'b0;
         r_en_d2   <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_wr_left <= '0;
      end else begin
         r_en_d1 <= r_ram_enb;
         r_en_d2 <= r_en_d1;
         if (w_accept) begin
            r_wr_left <= bus.length;
         end else if (w_wr) begin
            r_wr_left <= r_wr_left - (AW+1)'(1);
         end
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + FW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + FW'(1);
         end
         r_count <= r_count + {{FW{1'b0}}, w_wr} - {{FW{1'b0}}, w_rd};
      end
   end

   // FIFO storage; the last flag marks the word whose index is length-1.
   always_ff @(posedge clka) begin
      if (w_wr) begin
         r_mem[r_wr_ptr]      <= bus.ram_doutb;
         r_last_mem[r_wr_ptr] <= (r_wr_left == (AW+1)'(1));
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.ram_enb    = r_ram_enb;
   assign bus.ram_addrb  = r_ram_addrb;
   assign bus.ram_regceb = HP ? r_en_d1 : 1'b0;
   assign bus.m_valid    = w_valid;
   assign bus.m_data     = w_valid ? r_mem[r_rd_ptr] : '0;
   assign bus.m_last     = w_valid & r_last_mem[r_rd_ptr];
endmodule

// File: tb/tb_bram_rd_stream.sv
// Drives a HIGH_PERFORMANCE and a LOW_LATENCY instance with the same random bursts and
// checks each against a burst-level reference model (BRAM word at address a is a itself).
module tb_bram_rd_stream;
   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int DEPTH = 1024;

   logic          clka = 1'b0;
   logic          rstb = 1'b1;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          m_ready;
   bit            full_rate;
   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clka = ~clka;

   bram_rd_stream_if #(.AW(AW), .DW(DW)) if_hp ();
   bram_rd_stream_if #(.AW(AW), .DW(DW)) if_ll ();

   assign if_hp.start = start;  assign if_hp.base_addr = base_addr;
   assign if_hp.length = length; assign if_hp.m_ready = m_ready;
   assign if_ll.start = start;  assign if_ll.base_addr = base_addr;
   assign if_ll.length = length; assign if_ll.m_ready = m_ready;

   bram_rd_stream #(.RAM_WIDTH(DW), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .FIFO_DEPTH(4))
      u_hp (.clka(clka), .rstb(rstb), .bus(if_hp));
   bram_rd_stream #(.RAM_WIDTH(DW), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("LOW_LATENCY"), .FIFO_DEPTH(4))
      u_ll (.clka(clka), .rstb(rstb), .bus(if_ll));

   // BRAM models: two-stage with output register, and single-stage.
   logic [DW-1:0] hp_lat;
   always @(posedge clka) begin
      if (if_hp.ram_enb) hp_lat <= DW'(if_hp.ram_addrb);
      if (if_hp.ram_regceb) if_hp.ram_doutb <= hp_lat;
      if (if_ll.ram_enb) if_ll.ram_doutb <= DW'(if_ll.ram_addrb);
   end

   always @(posedge clka) cyc <= cyc + 1;

   logic          o_busy[2], o_done[2], o_enb[2], o_regce[2], o_valid[2], o_last[2];
   logic [AW-1:0] o_addr[2];
   logic [DW-1:0] o_data[2];
   assign o_busy[0] = if_hp.busy;   assign o_busy[1] = if_ll.busy;
   assign o_done[0] = if_hp.done;   assign o_done[1] = if_ll.done;
   assign o_enb[0] = if_hp.ram_enb; assign o_enb[1] = if_ll.ram_enb;
   assign o_regce[0] = if_hp.ram_regceb; assign o_regce[1] = if_ll.ram_regceb;
   assign o_valid[0] = if_hp.m_valid; assign o_valid[1] = if_ll.m_valid;
   assign o_last[0] = if_hp.m_last; assign o_last[1] = if_ll.m_last;
   assign o_addr[0] = if_hp.ram_addrb; assign o_addr[1] = if_ll.ram_addrb;
   assign o_data[0] = if_hp.m_data; assign o_data[1] = if_ll.m_data;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   string         dn[2] = '{"hp", "ll"};
   int            lat_c[2] = '{3, 2};
   bit            act[2], m_busy[2], pend_done[2], seen[2], stall[2], prev_enb[2];
   int            iss[2], beat[2], acc[2], mlen[2];
   logic [AW-1:0] mbase[2];
   logic [DW-1:0] hold_data[2];
   logic          hold_last[2];
   bit            prev_rst = 1'b1;

   // Reference model: checks last edge's outcome, then folds in this cycle's inputs.
   always @(negedge clka) begin
      for (int d = 0; d < 2; d++) begin
         bit acc_now;
         if (prev_rst) begin
            check_val({dn[d], ".rst_outputs"}, {o_busy[d], o_done[d], o_valid[d], o_last[d],
                      o_enb[d], o_regce[d], o_addr[d], o_data[d]}, 64'd0);
         end else begin
            check_val({dn[d], ".done"}, o_done[d], pend_done[d]);
            check_val({dn[d], ".busy"}, o_busy[d], m_busy[d]);
            check_val({dn[d], ".regceb"}, o_regce[d], (d == 0) ? prev_enb[d] : 1'b0);
            if (act[d] && !seen[d] && o_valid[d]) begin
               check_val({dn[d], ".first_valid_latency"}, cyc - acc[d], lat_c[d]);
               seen[d] = 1'b1;
            end
            if (stall[d])
               check_val({dn[d], ".hold"}, {o_valid[d], o_last[d], o_data[d]}, {1'b1, hold_last[d], hold_data[d]});
            if (full_rate && act[d] && seen[d])
               check_val({dn[d], ".throughput"}, o_valid[d], 1'b1);
         end
         pend_done[d] = 1'b0;
         if (rstb) begin
            act[d] = 1'b0; m_busy[d] = 1'b0; stall[d] = 1'b0;
         end else begin
            acc_now = start && !m_busy[d];
            if (o_enb[d]) begin
               check_val({dn[d], ".read_allowed"}, act[d] && (iss[d] < mlen[d]), 1'b1);
               check_val({dn[d], ".ram_addr"}, o_addr[d], (int'(mbase[d]) + iss[d]) % DEPTH);
               iss[d]++;
            end
            if (o_valid[d] && m_ready) begin
               check_val({dn[d], ".beat_allowed"}, act[d] && (beat[d] < mlen[d]), 1'b1);
               check_val({dn[d], ".data"}, o_data[d], (int'(mbase[d]) + beat[d]) % DEPTH);
               check_val({dn[d], ".last"}, o_last[d], beat[d] == mlen[d] - 1);
               beat[d]++;
               if (act[d] && beat[d] == mlen[d]) begin
                  check_val({dn[d], ".reads_issued"}, iss[d], mlen[d]);
                  pend_done[d] = 1'b1; m_busy[d] = 1'b0; act[d] = 1'b0;
               end
            end
            if (act[d]) check_val({dn[d], ".outstanding"}, (iss[d] - beat[d]) <= 4, 1'b1);
            if (acc_now) begin
               if (length == '0) begin
                  pend_done[d] = 1'b1;
               end else begin
                  m_busy[d] = 1'b1; act[d] = 1'b1; seen[d] = 1'b0;
                  mbase[d] = base_addr; mlen[d] = int'(length);
                  iss[d] = 0; beat[d] = 0; acc[d] = cyc + 1;
               end
            end
            stall[d] = o_valid[d] && !m_ready;
            hold_data[d] = o_data[d];
            hold_last[d] = o_last[d];
         end
         prev_enb[d] = o_enb[d];
      end
      prev_rst = rstb;
   end

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic burst(input int b, input int l);
      start = 1'b1; base_addr = AW'(b); length = (AW+1)'(l);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd, input int budget);
      int n = 0;
      while ((m_busy[0] || m_busy[1]) && n < budget) begin
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      if (m_busy[0] || m_busy[1]) check_val("timeout", {m_busy[0], m_busy[1]}, 2'b00);
      m_ready = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0; full_rate = 1'b0;
      repeat (3) tick();
      rstb = 1'b0;
      tick();
      m_ready = 1'b1; full_rate = 1'b1;
      burst(5, 8);
      wait_idle(1'b0, 200);
      full_rate = 1'b0;
      burst(1022, 4);
      wait_idle(1'b0, 200);
      burst(77, 0);
      wait_idle(1'b0, 20);
      burst(100, 6);
      tick();
      start = 1'b1; base_addr = AW'(300); length = (AW+1)'(3);
      tick();
      start = 1'b0;
      wait_idle(1'b0, 200);
      // Backpressure: random ready, then a long stall.
      burst(int'($urandom_range(0, DEPTH - 1)), 16);
      for (int i = 0; i < 12; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      m_ready = 1'b0;
      repeat (10) tick();
      wait_idle(1'b1, 1000);
      for (int k = 0; k < 8; k++) begin
         m_ready = 1'($urandom_range(0, 1));
         burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
         wait_idle(1'b1, 2000);
      end
      full_rate = 1'b1;
      burst(int'($urandom_range(0, DEPTH - 1)), DEPTH);
      wait_idle(1'b0, 3000);
      full_rate = 1'b0;
      // Reset in the middle of a burst, then restart right away.
      burst(200, 8);
      for (int n = 0; n < 50 && beat[0] < 3; n++) tick();
      check_val("midreset_progress", beat[0] >= 3, 1'b1);
      rstb = 1'b1;
      tick();
      rstb = 1'b0;
      burst(0, 2);
      wait_idle(1'b0, 100);
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/bram_rd_stream.md
BRAM_RD_STREAM -- requirements
Module: bram_rd_stream

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- RAM_WIDTH, 16, data width of the attached BRAM and of the output stream.
- RAM_DEPTH, 1024, number of BRAM entries; AW = $clog2(RAM_DEPTH).
- RAM_PERFORMANCE, "HIGH_PERFORMANCE", attached BRAM read latency: "HIGH_PERFORMANCE" = 2 cycles, "LOW_LATENCY" = 1 cycle.
- FIFO_DEPTH, 4, output buffer entries; power of 2, at least 4.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 Ports, one per line: name, direction, width, meaning.
- clka, in, 1, clock.
- rstb, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle request to begin a burst.
- base_addr, in, AW, first BRAM address; sampled when start is accepted.
- length, in, AW+1, number of words to read, 0..RAM_DEPTH; sampled when start is accepted.
- busy, out, 1, high from the accepted start until done.
- done, out, 1, one-cycle pulse after the last beat is transferred.
- ram_addrb, out, AW, BRAM read address.
- ram_enb, out, 1, BRAM read enable.
- ram_regceb, out, 1, BRAM output register enable.
- ram_doutb, in, RAM_WIDTH, BRAM read data.
- m_data, out, RAM_WIDTH, stream data.
- m_valid, out, 1, stream valid.
- m_ready, in, 1, stream ready.
- m_last, out, 1, marks the final beat of a burst.

Function
REQ-004 State machine states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN on start with length>0.
- RUN->DRAIN once all reads are issued.
- DRAIN->IDLE when the last beat is accepted (m_valid & m_ready & m_last).

REQ-005 start with length==0 SHALL stay in IDLE, issue no reads and no beats, and pulse done on the following cycle.

REQ-006 start SHALL be ignored when busy==1.

REQ-007 A read SHALL be issued (ram_enb=1) in RUN only when inflight + fifo_count < FIFO_DEPTH.
- inflight = reads issued whose data has not yet been written to the FIFO.
- This credit rule SHALL guarantee the FIFO never overflows.

REQ-008 Read issue rate SHALL be at most one per cycle.

REQ-009 ram_addrb SHALL equal base_addr for the first read and increment by 1 per issued read, wrapping from RAM_DEPTH-1 to 0.

REQ-010 Data capture SHALL follow the configured BRAM latency.
- HIGH_PERFORMANCE: ram_regceb SHALL be the 1-cycle delayed ram_enb, and ram_doutb SHALL be written to the FIFO 2 cycles after issue.
- LOW_LATENCY: ram_regceb=0, and ram_doutb SHALL be written 1 cycle after issue.

REQ-011 m_valid SHALL be high exactly when the FIFO is not empty, and m_data SHALL be the FIFO head.

REQ-012 A beat SHALL transfer on m_valid & m_ready, and m_data and m_last SHALL hold stable while m_valid & !m_ready.

REQ-013 m_last SHALL be high only on the beat whose index equals length-1.

REQ-014 With m_ready held high, throughput SHALL be one beat per cycle after the initial latency.
- First m_valid: 3 cycles after the accepted start in HIGH_PERFORMANCE, 2 cycles in LOW_LATENCY.

REQ-015 Simultaneous FIFO write and read SHALL leave fifo_count unchanged; this SHALL also hold when the FIFO is full or empty.

REQ-016 done SHALL pulse for one cycle, on the cycle after the last beat transfers, and busy SHALL deassert in that same cycle.

REQ-017 length==RAM_DEPTH SHALL read every address exactly once, wrapping back to base_addr-1.

Reset
REQ-018 While rstb=1 at a clock edge, the block SHALL:
- set the state to IDLE;
- clear the FIFO, inflight counter, issue and beat counters;
- drive busy=0, done=0, m_valid=0, m_last=0, ram_enb=0, ram_regceb=0, ram_addrb=0, m_data=0.

REQ-019 Reset asserted mid-burst SHALL abort the burst.
- Read data still in the BRAM pipeline SHALL be discarded.
- No done pulse SHALL be generated.
- The block SHALL accept start on the first cycle after rstb deasserts.

Verification
REQ-020 HIGH_PERFORMANCE burst: BRAM[i]=i, base_addr=5, length=8, m_ready=1 -> values 5..12 on 8 consecutive cycles; first m_valid 3 cycles after start; m_last on value 12; done on the next cycle.

REQ-021 Wrap: RAM_DEPTH=1024, base_addr=1022, length=4 -> addresses 1022,1023,0,1 in that order.

REQ-022 Backpressure: length=16, m_ready toggled randomly, then held low for 10 cycles -> no more than 4 reads outstanding+buffered, no data lost or duplicated, exactly 16 beats in order.

REQ-023 Zero length and busy-start: length=0 -> done 1 cycle later with no beats; start pulsed during a burst -> ignored.

REQ-024 Mid-burst reset: rstb pulsed after 3 of 8 beats -> all outputs at reset values next cycle, no done; a new start (base_addr=0, length=2) returns values 0,1.

REQ-025 LOW_LATENCY: same stimulus as REQ-020 -> same data; first m_valid 2 cycles after start; ram_regceb stays 0.
